// File: rtl/pc_fetch_sequencer.sv
// PC register and instruction-fetch sequencer for the MIPS core front end.
// Fetches via a request/ready handshake and holds each word for decode.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    output logic [31:0] epc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] epc_q, epc_d;
    logic        misalign_q, misalign_d;
    logic        imem_req_q, imem_req_d;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign epc         = epc_q;
    assign misalign    = misalign_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        epc_d         = epc_q;
        misalign_d    = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (exc) begin
                    // Redirect wins; any word returned this cycle is dropped
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end else if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (exc) begin
                    epc_d         = pc_q;
                    pc_d          = EXC_VECTOR;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                    if (jump) begin
                        pc_d       = {jump_target[31:2], 2'b00};
                        misalign_d = |jump_target[1:0];
                    end else if (branch_taken) begin
                        pc_d       = {branch_target[31:2], 2'b00};
                        misalign_d = |branch_target[1:0];
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        imem_req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            epc_q         <= 32'h0;
            misalign_q    <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            epc_q         <= epc_d;
            misalign_q    <= misalign_d;
            imem_req_q    <= imem_req_d;
        end
    end

endmodule
